// File: rtl/iter_shifter.sv
// ---------------------------------------------------------------------------
// iter_shifter : multi-cycle SLL/SRL/SRA/ROTR unit, STEP bits per cycle,
//                valid/ready on both sides.             Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [AMT_W-1:0] in_amt_i,
  input  logic [1:0]       in_mode_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_zero_o,
  output logic             busy_o
);

  localparam int         c_KW       = $clog2(STEP + 1);
  localparam logic [1:0] c_MODE_SLL = 2'b00;
  localparam logic [1:0] c_MODE_SRL = 2'b01;
  localparam logic [1:0] c_MODE_SRA = 2'b10;
  localparam logic [1:0] c_MODE_ROT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   data_q;
  logic [AMT_W-1:0]   remaining_q;
  logic [1:0]         mode_q;
  logic               sign_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_zero_q;
  logic               busy_q;

  logic [c_KW-1:0]    w_k;
  logic [WIDTH-1:0]   data_d;
  logic [AMT_W-1:0]   remaining_d;
  logic [WIDTH-1:0]   w_fill_mask;

  // Step size is clamped to what is left, so remaining never underflows.
  always_comb begin
    w_k = c_KW'(remaining_q);
    if (int'(remaining_q) >= STEP) begin
      w_k = c_KW'(STEP);
    end
    remaining_d = remaining_q - AMT_W'(w_k);
  end

  always_comb begin
    w_fill_mask = ~({WIDTH{1'b1}} >> w_k);
    data_d      = data_q;
    case (mode_q)
      c_MODE_SLL: data_d = data_q << w_k;
      c_MODE_SRL: data_d = data_q >> w_k;
      c_MODE_SRA: data_d = (data_q >> w_k) | (sign_q ? w_fill_mask : '0);
      c_MODE_ROT: data_d = (data_q >> w_k) | (data_q << (WIDTH - int'(w_k)));
      default:    data_d = data_q;
    endcase
  end

  // Flush outranks every other transition; outputs are all registered.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      remaining_q <= '0;
      mode_q      <= 2'b00;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush_i) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            data_q      <= in_data_i;
            mode_q      <= in_mode_i;
            remaining_q <= in_amt_i;
            sign_q      <= in_data_i[WIDTH-1];
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            if (in_amt_i == '0) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= in_data_i;
              out_zero_q  <= (in_data_i == '0);
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_q      <= data_d;
          remaining_q <= remaining_d;
          if (remaining_d == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= data_d;
            out_zero_q  <= (data_d == '0);
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_zero_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_zero_o  = out_zero_q;
  assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_shifter.sv
// ---------------------------------------------------------------------------
// tb_iter_shifter : scoreboard bench for iter_shifter (32/4 and 16/1 builds).
//                                                       Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iter_shifter;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROT = 2'b11;

  typedef struct {
    logic [31:0] d;
    logic        z;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_zero, a_busy;
  logic [31:0] a_in_data, a_out_data;
  logic [4:0]  a_in_amt;
  logic [1:0]  a_in_mode;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_zero, b_busy;
  logic [15:0] b_in_data, b_out_data;
  logic [3:0]  b_in_amt;
  logic [1:0]  b_in_mode;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  int          a_acc = 0, a_lat = 0, b_acc = 0, b_lat = 0;
  logic        a_pv = 1'b0, b_pv = 1'b0;

  iter_shifter #(.WIDTH(32), .STEP(4)) u_dut_a (
    .clock_i(clk), .reset_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .in_amt_i(a_in_amt), .in_mode_i(a_in_mode), .flush_i(a_flush),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_zero_o(a_out_zero), .busy_o(a_busy)
  );

  iter_shifter #(.WIDTH(16), .STEP(1)) u_dut_b (
    .clock_i(clk), .reset_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .in_amt_i(b_in_amt), .in_mode_i(b_in_mode), .flush_i(b_flush),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_zero_o(b_out_zero), .busy_o(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue_a(input logic [31:0] d, input logic [4:0] amt, input logic [1:0] mode,
                         input bit push, input logic [31:0] exp, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("a_ready_before_issue", a_in_ready, 1);
    a_in_valid = 1'b1; a_in_data = d; a_in_amt = amt; a_in_mode = mode;
    if (push) begin
      e.d = exp; e.z = (exp == 32'd0); e.lat = lat;
      sb_a.push_back(e);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic finish_a();
    int n;
    bit bad;
    n = 0; bad = 1'b0;
    while (!a_out_valid && n < 50) begin
      if (!a_busy) bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    chk("a_busy_during_op", (bad || !a_busy) ? 32'd0 : 32'd1, 1);
    chk("a_out_valid_seen", a_out_valid, 1);
    @(posedge clk); #1;
    chk("a_in_ready_after_hs", a_in_ready, 1);
    chk("a_out_valid_drop", a_out_valid, 0);
  endtask

  task automatic op_a(input logic [31:0] d, input logic [4:0] amt, input logic [1:0] mode,
                      input logic [31:0] exp, input int lat);
    issue_a(d, amt, mode, 1'b1, exp, lat);
    finish_a();
  endtask

  task automatic op_b(input logic [15:0] d, input logic [3:0] amt, input logic [1:0] mode,
                      input logic [15:0] exp, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!b_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("b_ready_before_issue", b_in_ready, 1);
    b_in_valid = 1'b1; b_in_data = d; b_in_amt = amt; b_in_mode = mode;
    e.d = {16'd0, exp}; e.z = (exp == 16'd0); e.lat = lat;
    sb_b.push_back(e);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("b_out_valid_seen", b_out_valid, 1);
    @(posedge clk); #1;
    chk("b_in_ready_after_hs", b_in_ready, 1);
  endtask

  initial begin
    int   n;
    bit   bad;
    exp_t e;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_in_amt = 0; a_in_mode = 0; a_flush = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = 0; b_in_amt = 0; b_in_mode = 0; b_flush = 0; b_out_ready = 1;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          a_pv = 1'b0; b_pv = 1'b0;
        end else begin
          if (a_out_valid && !a_pv) a_lat = cyc - a_acc + 1;
          a_pv = a_out_valid;
          if (a_out_valid && a_out_ready && !a_flush) begin
            if (sb_a.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL a_unexpected_output: got 0x%08h expected no output", a_out_data);
            end else begin
              e = sb_a.pop_front();
              chk("a_data", a_out_data, e.d);
              chk("a_zero", {31'd0, a_out_zero}, {31'd0, e.z});
              chk("a_latency", a_lat, e.lat);
            end
          end
          if (a_in_valid && a_in_ready && !a_flush) a_acc = cyc + 1;

          if (b_out_valid && !b_pv) b_lat = cyc - b_acc + 1;
          b_pv = b_out_valid;
          if (b_out_valid && b_out_ready && !b_flush) begin
            if (sb_b.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL b_unexpected_output: got 0x%04h expected no output", b_out_data);
            end else begin
              e = sb_b.pop_front();
              chk("b_data", {16'd0, b_out_data}, e.d);
              chk("b_zero", {31'd0, b_out_zero}, {31'd0, e.z});
              chk("b_latency", b_lat, e.lat);
            end
          end
          if (b_in_valid && b_in_ready && !b_flush) b_acc = cyc + 1;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_zero", a_out_zero, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_post_reset", a_in_ready, 1);

    // Directed vectors
    op_a(32'h0000_0001, 5'd31, M_SLL, 32'h8000_0000, 9);
    op_a(32'h8000_0000, 5'd5,  M_SRA, 32'hFC00_0000, 3);
    op_a(32'h8000_0000, 5'd5,  M_SRL, 32'h0400_0000, 3);
    op_a(32'h1234_5678, 5'd8,  M_ROT, 32'h7812_3456, 3);
    op_a(32'h0000_0000, 5'd0,  M_SLL, 32'h0000_0000, 1);
    op_a(32'h7000_0000, 5'd3,  M_SRA, 32'h0E00_0000, 2);
    op_a(32'h8000_0001, 5'd31, M_ROT, 32'h0000_0003, 9);
    op_a(32'hFFFF_FFFF, 5'd16, M_SLL, 32'hFFFF_0000, 5);
    op_a(32'h8000_0000, 5'd4,  M_SRL, 32'h0800_0000, 2);

    // Backpressure: result held, new request refused
    a_out_ready = 1'b0;
    issue_a(32'h0000_00FF, 5'd8, M_SLL, 1'b1, 32'h0000_FF00, 3);
    n = 0;
    while (!a_out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_valid_up", a_out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_in_data = 32'hAAAA_5555; a_in_amt = 5'd1; a_in_mode = M_SRL;
      @(posedge clk); #1;
      chk("bp_data_stable", a_out_data, 32'h0000_FF00);
      chk("bp_in_ready_low", a_in_ready, 0);
      chk("bp_valid_held", a_out_valid, 1);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_release", a_in_ready, 1);
    chk("bp_not_accepted", a_busy, 0);
    chk("bp_valid_release", a_out_valid, 0);

    // Flush on the second SHIFT cycle
    issue_a(32'h0000_0001, 5'd20, M_SLL, 1'b0, 32'd0, 0);
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    chk("flush_busy", a_busy, 0);
    chk("flush_valid", a_out_valid, 0);
    chk("flush_in_ready", a_in_ready, 1);
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (a_out_valid) bad = 1'b1;
    end
    chk("flush_no_valid_later", {31'd0, bad}, 0);

    // A request in the flush cycle is refused
    a_in_valid = 1'b1; a_in_data = 32'h1; a_in_amt = 5'd0; a_in_mode = M_SLL; a_flush = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_flush = 1'b0;
    chk("flush_blocks_accept", a_busy, 0);

    op_a(32'h0000_00F0, 5'd4, M_SRL, 32'h0000_000F, 2);

    // Flush together with out_ready in DONE drops the result
    a_out_ready = 1'b0;
    issue_a(32'h0000_0005, 5'd0, M_SLL, 1'b0, 32'd0, 0);
    chk("done_flush_pre_valid", a_out_valid, 1);
    a_out_ready = 1'b1; a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    chk("done_flush_valid", a_out_valid, 0);
    chk("done_flush_in_ready", a_in_ready, 1);

    // Asynchronous reset mid-SHIFT
    issue_a(32'h0000_0003, 5'd28, M_SLL, 1'b0, 32'd0, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", a_out_valid, 0);
    chk("arst_out_data", a_out_data, 0);
    chk("arst_out_zero", a_out_zero, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_in_ready", a_in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Narrow single-step build
    op_b(16'h1234, 4'd4, M_ROT, 16'h4123, 5);
    op_b(16'h8000, 4'd3, M_SRA, 16'hF000, 4);
    op_a(32'h1234_5678, 5'd8, M_ROT, 32'h7812_3456, 3);

    repeat (2) @(posedge clk);
    chk("a_sb_drained", sb_a.size(), 0);
    chk("b_sb_drained", sb_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iter_shifter.md
# iter_shifter

Parametrised multi-cycle shift/rotate unit for the execute stage. It generalises the single-cycle shifter in three ways: configurable datapath width, a four-mode operation set (including arithmetic right shift and rotate), and a valid/ready handshake on both sides. It trades latency for area by shifting at most STEP bit positions per cycle. It sits beside the ALU, fed from the ID/EX operand and shift-amount fields, with its result returning to the EX result mux.

## Interface
- WIDTH, default 32: operand/result width in bits; must be a power of two and at least 4.
- STEP, default 4: maximum bit positions shifted per cycle; must be a power of two, at most WIDTH.
- AMT_W, default $clog2(WIDTH): shift-amount width (derived; do not override).

- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts a request this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift amount, 0..WIDTH-1.
- in_mode  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- flush  in  1  synchronous abort; drops any in-flight or held result.
- out_valid  out  1  result held on out_data.
- out_ready  in  1  consumer takes the result this cycle.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0, qualified by out_valid.
- busy  out  1  state is not IDLE.

## Operation
- The FSM has three states:
  - IDLE: in_ready = 1. A transfer occurs when in_valid && in_ready. On transfer, latch data, mode, remaining = in_amt, and sign = in_data[WIDTH-1]. Go to DONE if in_amt == 0; otherwise go to SHIFT.
  - SHIFT: each cycle, shift the working register by k = min(STEP, remaining) and set remaining -= k. Go to DONE when remaining reaches 0 after this step.
  - DONE: out_valid = 1. When out_ready = 1, go to IDLE.
- Shift rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the latched sign bit (the original MSB), at every step.
  - ROTR moves bits leaving bit 0 into bit WIDTH-1.
- Arithmetic: remaining is AMT_W bits wide and never underflows. The result equals the single-cycle reference shift of in_data by in_amt.
- in_ready is 0 in SHIFT and DONE. There is no overlap between consecutive operations.
- flush has priority over every transition: the next state is IDLE, out_valid = 0, and the result is discarded. A request presented in the flush cycle is not accepted.
- A simultaneous flush and out_ready in DONE counts as a flush; the consumer must ignore the data.
- Reset at any time forces IDLE and clears the working register and remaining to 0, asynchronously.

## Timing
- Reset values:
  - in_ready = 0 while reset is high, 1 from the first cycle after deassertion.
  - out_valid = 0, out_data = 0, out_zero = 0, busy = 0.
- Latency from the accept edge to out_valid high is 1 + ceil(in_amt / STEP) cycles. in_amt = 0 gives 1 cycle. With defaults, in_amt = 31 gives 9 cycles.
- out_data and out_zero are registered and stay stable while out_valid && !out_ready.
- in_ready rises in the cycle after the out_ready handshake. Minimum issue interval is latency + 1 cycles.
- There is no combinational path from in_* or out_ready to out_data. in_ready depends only on state and reset.

## Test plan
- SLL 0x00000001 by 31, defaults -> out_data 0x80000000, out_valid 9 cycles after accept, busy high throughout.
- SRA 0x80000000 by 5 -> 0xFC000000 after 3 cycles. SRL of the same operand -> 0x04000000.
- ROTR 0x12345678 by 8 -> 0x78123456 after 3 cycles. Amount 0 on 0x00000000 -> 0x00000000, out_zero = 1, 1-cycle latency.
- Backpressure: hold out_ready low for 5 cycles after out_valid -> out_data constant, in_ready = 0, and a new in_valid is not accepted. Release -> in_ready = 1 on the next cycle.
- Flush during SHIFT (SLL by 20, flush on the 2nd SHIFT cycle) -> IDLE next cycle, out_valid never asserts. The following SRL 0xF0 by 4 -> 0x0F.
- Reset asserted mid-SHIFT -> all outputs 0 immediately (asynchronous). After release, repeat the ROTR case with STEP = 1, WIDTH = 16: 0x1234 by 4 -> 0x4123, latency 5.
